// File: rtl/rsv_issue_pip0.sv
// Reservation/issue buffer: an in-order circular queue of {uops, rd, pip} that exposes the oldest
// entry of each pipe and the head's pipe. Optional occupancy output when RSV_OCC_CNT_EN is defined.
module rsv_issue_pip0 #(
  parameter int W_PD_UOPS    = 6,
  parameter int W_PA_REG     = 5,
  parameter int W_PC_SEL_RSV = 2,
  parameter int W_PC_SEL_ODR = 2,
  parameter int S_amt_cell   = 8,
  parameter logic [W_PD_UOPS-1:0] unused_op = {W_PD_UOPS{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CDI_PC_valid,
  input  logic [W_PD_UOPS-1:0]    CDI_PD_uops,
  input  logic [W_PA_REG-1:0]     CDI_PD_rd,
  input  logic [1:0]              CDI_PC_pip,
  output logic                    CDO_PC_ready,
  output logic [W_PD_UOPS-1:0]    CDO_PD_uops0,
  output logic [W_PA_REG-1:0]     CDO_PD_rd0,
  output logic [W_PD_UOPS-1:0]    CDO_PD_uops1,
  output logic [W_PA_REG-1:0]     CDO_PD_rd1,
  output logic [W_PC_SEL_ODR-1:0] CDO_PC_odr,
  input  logic [W_PC_SEL_RSV-1:0] CDI_PC_selrsv,
  input  logic                    CFI_PC_clear
`ifdef RSV_OCC_CNT_EN
  ,
  output logic [$clog2(S_amt_cell):0] CDO_PC_occ
`endif
);

  localparam int PTR_W = $clog2(S_amt_cell);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic [W_PD_UOPS-1:0] uops_mem [S_amt_cell];
  logic [W_PA_REG-1:0]  rd_mem   [S_amt_cell];
  logic [1:0]           pip_mem  [S_amt_cell];

  logic push;
  logic pop;
  logic pip_ok;

  assign CDO_PC_ready = (count < CNT_W'(S_amt_cell));
  assign pip_ok       = (CDI_PC_pip == 2'b01) || (CDI_PC_pip == 2'b10);
  assign push         = CDI_PC_valid && CDO_PC_ready && (CDI_PD_uops != unused_op) && pip_ok;
  assign CDO_PC_odr   = (count != '0) ? W_PC_SEL_ODR'(pip_mem[head]) : '0;
  assign pop          = (CDO_PC_odr != '0) && (CDI_PC_selrsv == W_PC_SEL_RSV'(CDO_PC_odr));

  // Payload storage carries no reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      uops_mem[tail] <= CDI_PD_uops;
      rd_mem[tail]   <= CDI_PD_rd;
      pip_mem[tail]  <= CDI_PC_pip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (CFI_PC_clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Oldest-per-pipe search from head; the first hit in age order wins.
  always_comb begin
    logic             found0;
    logic             found1;
    logic [PTR_W-1:0] idx;
    CDO_PD_uops0 = unused_op;
    CDO_PD_rd0   = '0;
    CDO_PD_uops1 = unused_op;
    CDO_PD_rd1   = '0;
    found0       = 1'b0;
    found1       = 1'b0;
    idx          = '0;
    for (int i = 0; i < S_amt_cell; i++) begin
      idx = head + PTR_W'(i);
      if (i < int'(count)) begin
        if (!found0 && pip_mem[idx] == 2'b01) begin
          found0       = 1'b1;
          CDO_PD_uops0 = uops_mem[idx];
          CDO_PD_rd0   = rd_mem[idx];
        end
        if (!found1 && pip_mem[idx] == 2'b10) begin
          found1       = 1'b1;
          CDO_PD_uops1 = uops_mem[idx];
          CDO_PD_rd1   = rd_mem[idx];
        end
      end
    end
  end

`ifdef RSV_OCC_CNT_EN
  assign CDO_PC_occ = count;
`endif

endmodule

// File: tb/tb_rsv_issue_pip0.sv
// Directed bench for rsv_issue_pip0: reset, push/issue, full/drop, wrap, clear and async reset.
module tb_rsv_issue_pip0;
  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [5:0] uops;
  logic [4:0] rd;
  logic [1:0] pip;
  logic       ready;
  logic [5:0] uops0, uops1;
  logic [4:0] rd0, rd1;
  logic [1:0] odr;
  logic [1:0] selrsv;
  logic       clear;
`ifdef RSV_OCC_CNT_EN
  logic [3:0] occ;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] hd;

  rsv_issue_pip0 dut (
    .clk(clk), .rst(rst),
    .CDI_PC_valid(valid), .CDI_PD_uops(uops), .CDI_PD_rd(rd), .CDI_PC_pip(pip),
    .CDO_PC_ready(ready),
    .CDO_PD_uops0(uops0), .CDO_PD_rd0(rd0),
    .CDO_PD_uops1(uops1), .CDO_PD_rd1(rd1),
    .CDO_PC_odr(odr),
    .CDI_PC_selrsv(selrsv),
    .CFI_PC_clear(clear)
`ifdef RSV_OCC_CNT_EN
    , .CDO_PC_occ(occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ent(input logic [5:0] u, input logic [4:0] r, input logic [1:0] p);
    valid = 1'b1; uops = u; rd = r; pip = p;
    step();
    valid = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_ready"}, 32'(ready), 1);
    check_eq({tag, "_odr"},   32'(odr),   0);
    check_eq({tag, "_uops0"}, 32'(uops0), 'h3F);
    check_eq({tag, "_uops1"}, 32'(uops1), 'h3F);
    check_eq({tag, "_rd0"},   32'(rd0),   0);
    check_eq({tag, "_rd1"},   32'(rd1),   0);
  endtask

  function automatic logic [1:0] pip_of(int n);
    return (n % 3 == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [5:0] uops_of(int n);
    return 6'(32'h20 + n);
  endfunction

  initial begin
    rst = 1'b1; valid = 1'b0; uops = '0; rd = '0; pip = '0; selrsv = '0; clear = 1'b0;
    step(); step();
    check_empty("in_reset");
    rst = 1'b0;
    step();
    check_empty("after_reset");
`ifdef RSV_OCC_CNT_EN
    check_eq("occ_reset", 32'(occ), 0);
`endif

    // Two pushes, one to each pipe, then issue the pip0 head.
    push_ent(6'h05, 5'd3, 2'b01);
    check_eq("p1_odr",   32'(odr),   'h1);
    check_eq("p1_uops0", 32'(uops0), 'h05);
    check_eq("p1_rd0",   32'(rd0),   3);
    check_eq("p1_uops1", 32'(uops1), 'h3F);
    push_ent(6'h0A, 5'd7, 2'b10);
    check_eq("p2_odr",   32'(odr),   'h1);
    check_eq("p2_uops1", 32'(uops1), 'h0A);
    check_eq("p2_rd1",   32'(rd1),   7);
    selrsv = 2'b01; step(); selrsv = 2'b00;
    check_eq("pop1_odr",   32'(odr),   'h2);
    check_eq("pop1_uops0", 32'(uops0), 'h3F);
    check_eq("pop1_uops1", 32'(uops1), 'h0A);
    selrsv = 2'b10; step(); selrsv = 2'b00;
    check_empty("pop2");

    // Mismatched accept and illegal pushes leave state alone.
    push_ent(6'h11, 5'd1, 2'b01);
    selrsv = 2'b10; step(); selrsv = 2'b00;
    check_eq("badsel_odr",   32'(odr),   'h1);
    check_eq("badsel_uops0", 32'(uops0), 'h11);
    push_ent(6'h3F, 5'd2, 2'b01);
    push_ent(6'h12, 5'd2, 2'b11);
    push_ent(6'h13, 5'd2, 2'b00);
    check_eq("drop_uops1", 32'(uops1), 'h3F);
    check_eq("drop_uops0", 32'(uops0), 'h11);
    selrsv = 2'b01; step(); selrsv = 2'b00;
    check_empty("drop_single");

    // Fill to depth.
    for (int k = 0; k < 8; k++) begin
      push_ent(uops_of(k), 5'(k), pip_of(k));
      q.push_back({pip_of(k), uops_of(k)});
      check_eq($sformatf("fill%0d_ready", k), 32'(ready), (k < 7) ? 1 : 0);
`ifdef RSV_OCC_CNT_EN
      check_eq($sformatf("fill%0d_occ", k), 32'(occ), 32'(k + 1));
`endif
    end
    check_eq("full_odr",   32'(odr),   'h2);
    check_eq("full_uops1", 32'(uops1), 'h20);
    check_eq("full_rd1",   32'(rd1),   0);
    check_eq("full_uops0", 32'(uops0), 'h21);
    check_eq("full_rd0",   32'(rd0),   1);
    push_ent(6'h30, 5'd9, 2'b01);
    check_eq("ninth_ready", 32'(ready), 0);
    check_eq("ninth_odr",   32'(odr),   'h2);

    // Pop at full with a push offered: push refused since ready was low.
    valid = 1'b1; uops = 6'h31; rd = 5'd9; pip = 2'b01; selrsv = 2'b10;
    #1 check_eq("fullpp_ready_now", 32'(ready), 0);
    step();
    valid = 1'b0; selrsv = 2'b00;
    void'(q.pop_front());
    check_eq("fullpp_ready", 32'(ready), 1);
    check_eq("fullpp_odr",   32'(odr),   'h1);
    check_eq("fullpp_uops0", 32'(uops0), 'h21);
    check_eq("fullpp_uops1", 32'(uops1), 'h23);

    // Streaming push+pop across pointer wrap.
    for (int n = 8; n < 22; n++) begin
      hd = q[0];
      selrsv = hd[7:6];
      valid = 1'b1; uops = uops_of(n); rd = 5'(n); pip = pip_of(n);
      step();
      valid = 1'b0; selrsv = 2'b00;
      void'(q.pop_front());
      q.push_back({pip_of(n), uops_of(n)});
      hd = q[0];
      check_eq($sformatf("wrap%0d_ready", n), 32'(ready), 1);
      check_eq($sformatf("wrap%0d_odr", n), 32'(odr), 32'(hd[7:6]));
      if (hd[7:6] == 2'b01) check_eq($sformatf("wrap%0d_head", n), 32'(uops0), 32'(hd[5:0]));
      else                  check_eq($sformatf("wrap%0d_head", n), 32'(uops1), 32'(hd[5:0]));
    end
    for (int d = 0; d < 8 && q.size() > 0; d++) begin
      hd = q[0];
      selrsv = hd[7:6];
      step();
      selrsv = 2'b00;
      void'(q.pop_front());
      if (q.size() > 0) begin
        hd = q[0];
        check_eq($sformatf("drain%0d_odr", d), 32'(odr), 32'(hd[7:6]));
      end
    end
    check_empty("drained");

    // Clear beats a simultaneous push and matching pop.
    for (int k = 0; k < 5; k++) push_ent(uops_of(k), 5'(k), pip_of(k));
    check_eq("pre_clear_odr", 32'(odr), 'h2);
    clear = 1'b1; valid = 1'b1; uops = 6'h15; rd = 5'd4; pip = 2'b01; selrsv = 2'b10;
    step();
    clear = 1'b0; valid = 1'b0; selrsv = 2'b00;
    check_empty("clear");
`ifdef RSV_OCC_CNT_EN
    check_eq("clear_occ", 32'(occ), 0);
`endif
    push_ent(6'h07, 5'd2, 2'b01);
    check_eq("post_clear_uops0", 32'(uops0), 'h07);
    check_eq("post_clear_rd0",   32'(rd0),   2);

    // Asynchronous reset between edges.
    push_ent(6'h08, 5'd6, 2'b10);
    push_ent(6'h09, 5'd5, 2'b01);
    check_eq("pre_rst_uops1", 32'(uops1), 'h08);
    #3 rst = 1'b1;
    #1;
    check_empty("async_rst");
`ifdef RSV_OCC_CNT_EN
    check_eq("async_rst_occ", 32'(occ), 0);
`endif
    step();
    rst = 1'b0;
    step();
    check_empty("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
